// File: rtl/rvx_gpio_irq.sv
// GPIO peripheral: synchronised inputs, direct/atomic output control and
// sticky rise/fall edge interrupts, all behind a 32-byte register window.
module rvx_gpio_irq #(
   parameter int GPIO_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [4:0]            rw_address,
   output logic [31:0]           read_data,
   input  logic                  read_request,
   output logic                  read_response,
   input  logic [31:0]           write_data,
   input  logic [3:0]            write_strobe,
   input  logic                  write_request,
   output logic                  write_response,
   input  logic [GPIO_WIDTH-1:0] gpio_input,
   output logic [GPIO_WIDTH-1:0] gpio_output_enable,
   output logic [GPIO_WIDTH-1:0] gpio_output,
   output logic                  irq
);

   localparam logic [4:0] ADDR_INPUT    = 5'h00;
   localparam logic [4:0] ADDR_OE       = 5'h04;
   localparam logic [4:0] ADDR_OUTPUT   = 5'h08;
   localparam logic [4:0] ADDR_CLEAR    = 5'h0C;
   localparam logic [4:0] ADDR_SET      = 5'h10;
   localparam logic [4:0] ADDR_RISE_EN  = 5'h14;
   localparam logic [4:0] ADDR_FALL_EN  = 5'h18;
   localparam logic [4:0] ADDR_PENDING  = 5'h1C;
   localparam logic [2:0] WARM_INIT     = 3'(SYNC_STAGES + 1);

   logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [GPIO_WIDTH-1:0] sync_d [SYNC_STAGES];
   logic [GPIO_WIDTH-1:0] prev_q, prev_d;
   logic [GPIO_WIDTH-1:0] oe_q, oe_d;
   logic [GPIO_WIDTH-1:0] out_q, out_d;
   logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
   logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
   logic [GPIO_WIDTH-1:0] pend_q, pend_d;
   logic [2:0]            warm_q, warm_d;
   logic                  irq_q, irq_d;
   logic [31:0]           read_data_q, read_data_d;
   logic                  read_response_q, read_response_d;
   logic                  write_response_q, write_response_d;

   logic [GPIO_WIDTH-1:0] sync_in;
   logic [GPIO_WIDTH-1:0] pin_value;
   logic [GPIO_WIDTH-1:0] wdata;
   logic [GPIO_WIDTH-1:0] w1c_mask;
   logic [GPIO_WIDTH-1:0] set_mask;
   logic                  write_ok;
   logic                  unused_wdata;

   assign unused_wdata = ^write_data;

   always_comb begin
      sync_in   = sync_q[SYNC_STAGES-1];
      sync_d[0] = gpio_input;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      prev_d = sync_in;

      // Edges are ignored until the synchroniser and prev register have
      // been filled from the live pins, so pins high out of reset stay quiet.
      if (warm_q != 3'd0) begin
         warm_d   = warm_q - 3'd1;
         set_mask = '0;
      end else begin
         warm_d   = warm_q;
         set_mask = ((sync_in & ~prev_q) & rise_en_q) |
                    ((~sync_in & prev_q) & fall_en_q);
      end

      write_ok = write_request &&
                 (write_strobe == 4'b1111 || write_strobe == 4'b0011 ||
                  write_strobe == 4'b0001);
      wdata     = write_data[GPIO_WIDTH-1:0];
      oe_d      = oe_q;
      out_d     = out_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      w1c_mask  = '0;
      if (write_ok) begin
         case (rw_address)
            ADDR_OE:      oe_d      = wdata;
            ADDR_OUTPUT:  out_d     = wdata;
            ADDR_CLEAR:   out_d     = out_q & ~wdata;
            ADDR_SET:     out_d     = out_q | wdata;
            ADDR_RISE_EN: rise_en_d = wdata;
            ADDR_FALL_EN: fall_en_d = wdata;
            ADDR_PENDING: w1c_mask  = wdata;
            default:      ;
         endcase
      end
      pend_d = (pend_q & ~w1c_mask) | set_mask;
      irq_d  = |pend_q;

      pin_value   = (oe_q & out_q) | (~oe_q & sync_in);
      read_data_d = '0;
      if (read_request) begin
         case (rw_address)
            ADDR_INPUT:   read_data_d = 32'(pin_value);
            ADDR_OE:      read_data_d = 32'(oe_q);
            ADDR_OUTPUT:  read_data_d = 32'(out_q);
            ADDR_RISE_EN: read_data_d = 32'(rise_en_q);
            ADDR_FALL_EN: read_data_d = 32'(fall_en_q);
            ADDR_PENDING: read_data_d = 32'(pend_q);
            default:      read_data_d = '0;
         endcase
      end
      read_response_d  = read_request;
      write_response_d = write_request;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         prev_q           <= '0;
         oe_q             <= '0;
         out_q            <= '0;
         rise_en_q        <= '0;
         fall_en_q        <= '0;
         pend_q           <= '0;
         warm_q           <= WARM_INIT;
         irq_q            <= 1'b0;
         read_data_q      <= '0;
         read_response_q  <= 1'b0;
         write_response_q <= 1'b0;
      end else begin
         sync_q           <= sync_d;
         prev_q           <= prev_d;
         oe_q             <= oe_d;
         out_q            <= out_d;
         rise_en_q        <= rise_en_d;
         fall_en_q        <= fall_en_d;
         pend_q           <= pend_d;
         warm_q           <= warm_d;
         irq_q            <= irq_d;
         read_data_q      <= read_data_d;
         read_response_q  <= read_response_d;
         write_response_q <= write_response_d;
      end
   end

   assign read_data          = read_data_q;
   assign read_response      = read_response_q;
   assign write_response     = write_response_q;
   assign gpio_output_enable = oe_q;
   assign gpio_output        = out_q;
   assign irq                = irq_q;

endmodule

// File: tb/tb_rvx_gpio_irq.sv
// Directed bench for rvx_gpio_irq: a 32-pin and an 8-pin instance share
// the register bus; vector table plus hand sequences for edge/IRQ timing.
module tb_rvx_gpio_irq;

   localparam int SYNC = 2;

   logic        clock;
   logic        reset_n;
   logic [4:0]  rw_address;
   logic        read_request;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_request;

   logic [31:0] read_data, read_data8;
   logic        read_response, read_response8;
   logic        write_response, write_response8;
   logic [31:0] gpio_input, gpio_oe, gpio_out;
   logic [7:0]  gin8, goe8, gout8;
   logic        irq, irq8;

   int checks   = 0;
   int failures = 0;

   rvx_gpio_irq #(.GPIO_WIDTH(32), .SYNC_STAGES(SYNC)) dut (
      .clock(clock), .reset_n(reset_n), .rw_address(rw_address),
      .read_data(read_data), .read_request(read_request),
      .read_response(read_response), .write_data(write_data),
      .write_strobe(write_strobe), .write_request(write_request),
      .write_response(write_response), .gpio_input(gpio_input),
      .gpio_output_enable(gpio_oe), .gpio_output(gpio_out), .irq(irq)
   );

   rvx_gpio_irq #(.GPIO_WIDTH(8), .SYNC_STAGES(SYNC)) dut8 (
      .clock(clock), .reset_n(reset_n), .rw_address(rw_address),
      .read_data(read_data8), .read_request(read_request),
      .read_response(read_response8), .write_data(write_data),
      .write_strobe(write_strobe), .write_request(write_request),
      .write_response(write_response8), .gpio_input(gin8),
      .gpio_output_enable(goe8), .gpio_output(gout8), .irq(irq8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [4:0]  raddr;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t vecs [17];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      rw_address    = a;
      write_data    = d;
      write_strobe  = s;
      write_request = 1'b1;
      tick();
      chk("write_response", 32'(write_response), 32'd1);
      write_request = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic [31:0] d8);
      rw_address   = a;
      read_request = 1'b1;
      tick();
      chk("read_response", 32'(read_response), 32'd1);
      d  = read_data;
      d8 = read_data8;
      read_request = 1'b0;
   endtask

   logic [31:0] rd, rd8;

   initial begin
      vecs[0]  = '{5'h04, 32'h0000FFFF, 4'hF, 5'h04, 32'h0000FFFF, 32'h00000000};
      vecs[1]  = '{5'h08, 32'h12345678, 4'hF, 5'h00, 32'hABCD5678, 32'h12345678};
      vecs[2]  = '{5'h00, 32'hFFFFFFFF, 4'hF, 5'h00, 32'hABCD5678, 32'h12345678};
      vecs[3]  = '{5'h08, 32'h00000000, 4'hF, 5'h08, 32'h00000000, 32'h00000000};
      vecs[4]  = '{5'h10, 32'h0000000F, 4'hF, 5'h08, 32'h0000000F, 32'h0000000F};
      vecs[5]  = '{5'h0C, 32'h00000005, 4'hF, 5'h08, 32'h0000000A, 32'h0000000A};
      vecs[6]  = '{5'h10, 32'hFFFFFFFF, 4'h4, 5'h08, 32'h0000000A, 32'h0000000A};
      vecs[7]  = '{5'h10, 32'h000000F0, 4'h3, 5'h08, 32'h000000FA, 32'h000000FA};
      vecs[8]  = '{5'h10, 32'h00000100, 4'h1, 5'h08, 32'h000001FA, 32'h000001FA};
      vecs[9]  = '{5'h08, 32'hFFFFFFFF, 4'h8, 5'h08, 32'h000001FA, 32'h000001FA};
      vecs[10] = '{5'h0C, 32'hFFFFFFFF, 4'hF, 5'h0C, 32'h00000000, 32'h00000000};
      vecs[11] = '{5'h10, 32'hFFFF0000, 4'hF, 5'h10, 32'h00000000, 32'hFFFF0000};
      vecs[12] = '{5'h02, 32'h12345678, 4'hF, 5'h08, 32'hFFFF0000, 32'hFFFF0000};
      vecs[13] = '{5'h14, 32'h000000A5, 4'hF, 5'h15, 32'h00000000, 32'hFFFF0000};
      vecs[14] = '{5'h18, 32'h0000005A, 4'hF, 5'h18, 32'h0000005A, 32'hFFFF0000};
      vecs[15] = '{5'h14, 32'h00000000, 4'hF, 5'h14, 32'h00000000, 32'hFFFF0000};
      vecs[16] = '{5'h18, 32'h00000000, 4'hF, 5'h18, 32'h00000000, 32'hFFFF0000};

      reset_n       = 1'b0;
      rw_address    = '0;
      read_request  = 1'b0;
      write_data    = '0;
      write_strobe  = '0;
      write_request = 1'b0;
      gpio_input    = 32'hFFFFFFFF;
      gin8          = 8'hFF;
      repeat (3) tick();

      chk("rst read_response", 32'(read_response), 32'd0);
      chk("rst write_response", 32'(write_response), 32'd0);
      chk("rst read_data", read_data, 32'd0);
      chk("rst gpio_output", gpio_out, 32'd0);
      chk("rst gpio_oe", gpio_oe, 32'd0);
      chk("rst irq", 32'(irq), 32'd0);

      // Pins high out of reset must not raise PENDING even with RISE_EN set.
      reset_n = 1'b1;
      bus_write(5'h14, 32'hFFFFFFFF, 4'hF);
      bus_read(5'h00, rd, rd8);
      chk("warm input early", rd, 32'h00000000);
      bus_read(5'h00, rd, rd8);
      chk("warm input settled", rd, 32'hFFFFFFFF);
      repeat (4) tick();
      chk("warm irq", 32'(irq), 32'd0);
      chk("warm irq8", 32'(irq8), 32'd0);
      bus_read(5'h1C, rd, rd8);
      chk("warm pending", rd, 32'd0);
      chk("warm pending8", rd8, 32'd0);

      bus_write(5'h14, 32'h0, 4'hF);
      gpio_input = 32'hABCD0000;
      gin8       = 8'h00;
      repeat (4) tick();

      for (int i = 0; i < 17; i++) begin
         bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb);
         bus_read(vecs[i].raddr, rd, rd8);
         chk($sformatf("vec%0d read", i), rd, vecs[i].exp_rd);
         chk($sformatf("vec%0d gpio_output", i), gpio_out, vecs[i].exp_out);
      end
      chk("gpio_oe", gpio_oe, 32'h0000FFFF);

      // Same-cycle read and write: read sees the old value.
      rw_address    = 5'h08;
      write_data    = 32'h0;
      write_strobe  = 4'hF;
      write_request = 1'b1;
      read_request  = 1'b1;
      tick();
      chk("rmw read old", read_data, 32'hFFFF0000);
      chk("rmw write_response", 32'(write_response), 32'd1);
      write_request = 1'b0;
      read_request  = 1'b0;
      tick();
      chk("response one cycle", 32'(read_response), 32'd0);
      bus_read(5'h08, rd, rd8);
      chk("rmw new value", rd, 32'h0);

      // Rise on pin0, fall on pin1; exact PENDING and irq timing.
      gpio_input = 32'hABCD0002;
      repeat (5) tick();
      bus_write(5'h14, 32'h1, 4'hF);
      bus_write(5'h18, 32'h2, 4'hF);
      bus_read(5'h1C, rd, rd8);
      chk("edge pending idle", rd, 32'h0);
      gpio_input = 32'hABCD0001;
      repeat (SYNC) tick();
      chk("edge irq early", 32'(irq), 32'd0);
      bus_read(5'h1C, rd, rd8);
      chk("edge pending before", rd, 32'h0);
      chk("edge irq before", 32'(irq), 32'd0);
      bus_read(5'h1C, rd, rd8);
      chk("edge pending set", rd, 32'h3);
      chk("edge irq set", 32'(irq), 32'd1);
      bus_write(5'h1C, 32'h1, 4'hF);
      bus_read(5'h1C, rd, rd8);
      chk("w1c bit0", rd, 32'h2);
      chk("irq held", 32'(irq), 32'd1);
      bus_write(5'h1C, 32'h2, 4'hF);
      chk("irq lag", 32'(irq), 32'd1);
      tick();
      chk("irq cleared", 32'(irq), 32'd0);

      // W1C on the same cycle as a new rising edge: set wins.
      gpio_input = 32'hABCD0000;
      repeat (5) tick();
      bus_read(5'h1C, rd, rd8);
      chk("no fall pending", rd, 32'h0);
      gpio_input = 32'hABCD0001;
      repeat (SYNC) tick();
      bus_write(5'h1C, 32'h1, 4'hF);
      bus_read(5'h1C, rd, rd8);
      chk("set beats w1c", rd, 32'h1);
      bus_write(5'h14, 32'h0, 4'hF);
      bus_read(5'h1C, rd, rd8);
      chk("rise_en clear keeps pending", rd, 32'h1);
      bus_write(5'h1C, 32'h1, 4'hF);
      bus_read(5'h1C, rd, rd8);
      chk("pending cleared", rd, 32'h0);

      // 8-pin instance: upper bits read 0.
      bus_write(5'h08, 32'hFFFFFFFF, 4'hF);
      bus_read(5'h08, rd, rd8);
      chk("w8 output read", rd8, 32'h000000FF);
      chk("w32 output read", rd, 32'hFFFFFFFF);
      chk("w8 gpio_output", 32'(gout8), 32'h000000FF);
      bus_write(5'h14, 32'hFFFFFFFF, 4'hF);
      gin8 = 8'hFF;
      repeat (5) tick();
      bus_read(5'h1C, rd, rd8);
      chk("w8 pending", rd8, 32'h000000FF);
      chk("w8 irq", 32'(irq8), 32'd1);

      // Reset with a read in flight: no acknowledge, all state cleared.
      rw_address   = 5'h1C;
      read_request = 1'b1;
      reset_n      = 1'b0;
      tick();
      chk("midrst read_response8", 32'(read_response8), 32'd0);
      chk("midrst read_response", 32'(read_response), 32'd0);
      chk("midrst irq8", 32'(irq8), 32'd0);
      chk("midrst gpio_output8", 32'(gout8), 32'd0);
      chk("midrst read_data8", read_data8, 32'd0);
      read_request = 1'b0;
      reset_n      = 1'b1;
      repeat (5) tick();
      bus_read(5'h1C, rd, rd8);
      chk("midrst pending8", rd8, 32'd0);
      bus_read(5'h14, rd, rd8);
      chk("midrst rise_en8", rd8, 32'd0);
      bus_read(5'h08, rd, rd8);
      chk("midrst output8", rd8, 32'd0);
      chk("midrst output32", rd, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rvx_gpio_irq.md
Name: rvx_gpio_irq

Overview:
- Parametrised general-purpose I/O peripheral with a per-pin input synchroniser, per-pin rising/falling edge interrupt detection, and a sticky write-1-to-clear pending register.
- Provides direct output drive, output-enable control and atomic set/clear of outputs.
- Sits on the peripheral register bus next to the other RVX peripherals.
- Drives one level interrupt line to the core's interrupt controller.

Parameters:
- GPIO_WIDTH, 32, number of pins; legal 1..32; unused upper register bits read 0 and ignore writes.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; legal 2..4.

Ports:
- clock  input  1  single clock; all logic is rising-edge clocked.
- reset_n  input  1  synchronous, active-low reset.
- rw_address  input  5  byte address of register within the 32-byte window.
- read_data  output  32  read data, valid when read_response=1.
- read_request  input  1  read strobe, one cycle.
- read_response  output  1  read acknowledge.
- write_data  input  32  write data.
- write_strobe  input  4  byte enables.
- write_request  input  1  write strobe, one cycle.
- write_response  output  1  write acknowledge.
- gpio_input  input  GPIO_WIDTH  asynchronous pin inputs.
- gpio_output_enable  output  GPIO_WIDTH  per-pin drive enable.
- gpio_output  output  GPIO_WIDTH  per-pin output value.
- irq  output  1  registered level interrupt: OR of pending bits.

Behaviour:
- Reset: read_data, read_response, write_response, gpio_output_enable, gpio_output, irq, RISE_EN, FALL_EN, PENDING, synchroniser stages and previous-sample register are all 0.
- Warm-up counter loads SYNC_STAGES+1 on reset.
- Bus handshake: read_response and write_response equal the previous cycle's read_request and write_request, so latency is exactly 1 cycle. Every request is acknowledged, including bad addresses and bad strobes.
- Valid write: write_request=1 and write_strobe is one of 4'b1111, 4'b0011 or 4'b0001. Any other strobe is acknowledged with no state change.
- Data uses write_data[GPIO_WIDTH-1:0] regardless of strobe.
- Register map (rw_address; R=read, W=write):
  - 0x00 INPUT, R: (oe & out) | (~oe & sync_in). Writes ignored.
  - 0x04 OUTPUT_ENABLE, R/W.
  - 0x08 OUTPUT, R/W.
  - 0x0C CLEAR, W: out &= ~data. Reads 0.
  - 0x10 SET, W: out |= data. Reads 0.
  - 0x14 RISE_EN, R/W.
  - 0x18 FALL_EN, R/W.
  - 0x1C PENDING, R; write-1-to-clear.
  - Unaligned or unlisted addresses read 0 and ignore writes.
- Read data is registered on the request cycle. It reflects state before any write in that same cycle.
- Synchroniser: sync_in is the last stage of a SYNC_STAGES shift register fed from gpio_input.
- Edge detection: prev <= sync_in every cycle.
  - rise = sync_in & ~prev
  - fall = ~sync_in & prev
  - set_mask = (rise & RISE_EN) | (fall & FALL_EN)
- Warm-up: while the counter is nonzero it decrements, and set_mask is forced to 0. This suppresses spurious edges from pins that are high out of reset.
- PENDING update: PENDING <= (PENDING & ~w1c_mask) | set_mask. Set wins over a simultaneous W1C on the same bit.
- Clearing RISE_EN or FALL_EN does not clear PENDING.
- Edges on output-driven pins are still detected from gpio_input.
- irq <= |PENDING (registered). An input toggle at cycle t gives PENDING at t+SYNC_STAGES+1 and irq one cycle later.
- Reset asserted mid-operation: all state returns to reset values on the next clock edge and warm-up restarts. An outstanding request is not acknowledged.

Test Plan:
- Reset with gpio_input=all-ones, RISE_EN=FFFFFFFF written right after reset -> PENDING stays 0, irq=0. INPUT reads FFFFFFFF after SYNC_STAGES cycles.
- Write OUTPUT_ENABLE=0000FFFF, OUTPUT=12345678, gpio_input=ABCD0000 -> INPUT reads ABCD5678; read_response exactly 1 cycle after request.
- SET 0x0F then CLEAR 0x05 from OUTPUT=0 -> gpio_output=0x0A. Write with strobe 4'b0100 -> no change, write_response still 1.
- RISE_EN=1, FALL_EN=2; toggle pin0 0→1 and pin1 1→0 -> PENDING=3 at t+SYNC_STAGES+1 and irq=1 next cycle. W1C 0x1 -> PENDING=2; W1C 0x2 -> irq falls 1 cycle later.
- W1C of bit 0 in the same cycle a new rising edge on pin0 reaches set_mask -> bit 0 remains 1.
- GPIO_WIDTH=8: write FFFFFFFF to OUTPUT -> reads 000000FF. Reset asserted mid-pulse with PENDING=FF -> all registers 0 and no response for the in-flight request.
